// File: rtl/ident_scanner.sv
// Registered scanner for identifiers (letter run followed by digits) with length, overflow and
// end-of-token reporting. Define IDENT_UNDERSCORE_EN to class '_' (0x5F) as a letter.
module ident_scanner #(
    parameter int MIN_ALPHA = 1,
    parameter int MAX_LEN   = 31,
    parameter int LEN_W     = 5,
    parameter int STRICT    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             char_valid,
    input  logic [7:0]       char,
    output logic             out,
    output logic [LEN_W-1:0] id_len,
    output logic             overflow,
    output logic             tok_done,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_ok
);

    typedef enum logic [1:0] {IDLE, ALPHA, DIGIT, SKIP} state_e;
    typedef enum logic [1:0] {CL_LET, CL_DIG, CL_DLM} cls_e;

    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO_L  = '0;
    localparam logic [3:0]       MIN_A   = 4'(MIN_ALPHA);
    localparam logic [3:0]       ARUN_MX = 4'd15;
    localparam state_e           ABORT_S = (STRICT != 0) ? SKIP : IDLE;

    function automatic cls_e classify(input logic [7:0] c);
        cls_e r;
        r = CL_DLM;
        if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A))
            r = CL_LET;
        else if (c >= 8'h30 && c <= 8'h39)
            r = CL_DIG;
`ifdef IDENT_UNDERSCORE_EN
        else if (c == 8'h5F)
            r = CL_LET;
`endif
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [3:0]       arun_q, arun_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;
    logic             tok_ok_q, tok_ok_d;

    cls_e             cls;
    logic             len_at_max;
    logic [LEN_W-1:0] len_inc;
    logic [3:0]       arun_inc;
    logic             qual;

    assign cls        = classify(char);
    assign len_at_max = (len_q >= MAX_L);
    // Growing past MAX_LEN pins the length and latches overflow instead of wrapping
    assign len_inc    = len_at_max ? MAX_L : (len_q + ONE_L);
    assign arun_inc   = (arun_q == ARUN_MX) ? ARUN_MX : (arun_q + 4'd1);

    always_comb begin
        state_d   = state_q;
        arun_d    = arun_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        out_d     = out_q;
        done_d    = 1'b0;
        tok_len_d = tok_len_q;
        tok_ok_d  = tok_ok_q;
        qual      = 1'b0;

        if (char_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (cls == CL_LET) begin
                        state_d = ALPHA;
                        len_d   = ONE_L;
                        arun_d  = 4'd1;
                        ovf_d   = 1'b0;
                    end else if (cls == CL_DIG) begin
                        state_d = ABORT_S;
                    end
                end
                ALPHA: begin
                    if (cls == CL_LET) begin
                        arun_d = arun_inc;
                        len_d  = len_inc;
                        ovf_d  = ovf_q | len_at_max;
                    end else if (cls == CL_DIG) begin
                        if (arun_q >= MIN_A) begin
                            state_d = DIGIT;
                            len_d   = len_inc;
                            ovf_d   = ovf_q | len_at_max;
                            qual    = 1'b1;
                        end else begin
                            // Too few letters: the candidate is dropped without a token report
                            state_d = ABORT_S;
                            len_d   = ZERO_L;
                            ovf_d   = 1'b0;
                            arun_d  = 4'd0;
                        end
                    end else begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        tok_len_d = len_q;
                        tok_ok_d  = 1'b0;
                        len_d     = ZERO_L;
                        ovf_d     = 1'b0;
                        arun_d    = 4'd0;
                    end
                end
                DIGIT: begin
                    if (cls == CL_DIG) begin
                        len_d = len_inc;
                        ovf_d = ovf_q | len_at_max;
                        qual  = 1'b1;
                    end else if (cls == CL_LET) begin
                        state_d = ALPHA;
                        arun_d  = 4'd1;
                        len_d   = len_inc;
                        ovf_d   = ovf_q | len_at_max;
                    end else begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        tok_len_d = len_q;
                        tok_ok_d  = ~ovf_q;
                        len_d     = ZERO_L;
                        ovf_d     = 1'b0;
                        arun_d    = 4'd0;
                    end
                end
                SKIP: begin
                    if (cls == CL_DLM)
                        state_d = IDLE;
                end
            endcase
            out_d = qual & ~ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            arun_q    <= 4'd0;
            len_q     <= ZERO_L;
            ovf_q     <= 1'b0;
            out_q     <= 1'b0;
            done_q    <= 1'b0;
            tok_len_q <= ZERO_L;
            tok_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arun_q    <= arun_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            out_q     <= out_d;
            done_q    <= done_d;
            tok_len_q <= tok_len_d;
            tok_ok_q  <= tok_ok_d;
        end
    end

    assign out      = out_q;
    assign id_len   = len_q;
    assign overflow = ovf_q;
    assign tok_done = done_q;
    assign tok_len  = tok_len_q;
    assign tok_ok   = tok_ok_q;

endmodule

// File: tb/tb_ident_scanner.sv
// Bench for ident_scanner: four parameterisations driven with one stream and scored against
// a behavioural model through an expected-value queue.
module tb_ident_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [7:0] ch;

    always #5 clk = ~clk;

    logic [3:0] out_w, ovf_w, done_w, ok_w;
    logic [4:0] len0, len1, len2, tl0, tl1, tl2;
    logic [2:0] len3, tl3;

    // u0 default, u1 MIN_ALPHA=2, u2 STRICT=1, u3 MAX_LEN=4/LEN_W=3
    ident_scanner #(.MIN_ALPHA(1), .MAX_LEN(31), .LEN_W(5), .STRICT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char(ch),
        .out(out_w[0]), .id_len(len0), .overflow(ovf_w[0]), .tok_done(done_w[0]),
        .tok_len(tl0), .tok_ok(ok_w[0]));
    ident_scanner #(.MIN_ALPHA(2), .MAX_LEN(31), .LEN_W(5), .STRICT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char(ch),
        .out(out_w[1]), .id_len(len1), .overflow(ovf_w[1]), .tok_done(done_w[1]),
        .tok_len(tl1), .tok_ok(ok_w[1]));
    ident_scanner #(.MIN_ALPHA(1), .MAX_LEN(31), .LEN_W(5), .STRICT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char(ch),
        .out(out_w[2]), .id_len(len2), .overflow(ovf_w[2]), .tok_done(done_w[2]),
        .tok_len(tl2), .tok_ok(ok_w[2]));
    ident_scanner #(.MIN_ALPHA(1), .MAX_LEN(4), .LEN_W(3), .STRICT(0)) u3 (
        .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char(ch),
        .out(out_w[3]), .id_len(len3), .overflow(ovf_w[3]), .tok_done(done_w[3]),
        .tok_len(tl3), .tok_ok(ok_w[3]));

    typedef struct {
        int st;   // 0 idle, 1 alpha, 2 digit, 3 skip
        int arun;
        int len;
        bit ovf;
        bit out;
        bit done;
        int tlen;
        bit ok;
    } mdl_t;

    typedef struct {
        int          k;
        logic [15:0] v;
    } sb_t;

    int   cfg_min    [4] = '{1, 2, 1, 1};
    int   cfg_max    [4] = '{31, 31, 31, 4};
    bit   cfg_strict [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    mdl_t mdl        [4];
    sb_t  sbq [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs(input int k);
        case (k)
            0:       return {2'b0, out_w[0], len0, ovf_w[0], done_w[0], tl0, ok_w[0]};
            1:       return {2'b0, out_w[1], len1, ovf_w[1], done_w[1], tl1, ok_w[1]};
            2:       return {2'b0, out_w[2], len2, ovf_w[2], done_w[2], tl2, ok_w[2]};
            default: return {2'b0, out_w[3], 2'b0, len3, ovf_w[3], done_w[3], 2'b0, tl3, ok_w[3]};
        endcase
    endfunction

    function automatic logic [15:0] pack(input mdl_t m);
        return {2'b0, m.out, 5'(m.len), m.ovf, m.done, 5'(m.tlen), m.ok};
    endfunction

    function automatic mdl_t mzero();
        mdl_t z;
        z.st = 0; z.arun = 0; z.len = 0; z.ovf = 0;
        z.out = 0; z.done = 0; z.tlen = 0; z.ok = 0;
        return z;
    endfunction

    // 1 = letter, 2 = digit, 0 = delimiter
    function automatic int cls(input logic [7:0] c);
        if ((c >= "A" && c <= "Z") || (c >= "a" && c <= "z")) return 1;
        if (c >= "0" && c <= "9") return 2;
`ifdef IDENT_UNDERSCORE_EN
        if (c == "_") return 1;
`endif
        return 0;
    endfunction

    function automatic mdl_t grow(input mdl_t n, input int k);
        mdl_t r = n;
        if (n.len + 1 > cfg_max[k]) begin
            r.len = cfg_max[k];
            r.ovf = 1'b1;
        end else begin
            r.len = n.len + 1;
        end
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t s, input int k, input logic [7:0] c, input bit v);
        mdl_t n;
        bit   qual;
        int   cl;
        n = s;
        n.done = 1'b0;
        qual = 1'b0;
        if (!v) return n;
        cl = cls(c);
        if (s.st == 0) begin
            if (cl == 1) begin
                n.st = 1; n.len = 1; n.arun = 1; n.ovf = 0;
            end else if (cl == 2 && cfg_strict[k]) begin
                n.st = 3;
            end
        end else if (s.st == 1 || s.st == 2) begin
            if (cl == 0) begin
                n.done = 1'b1;
                n.tlen = s.len;
                n.ok   = (s.st == 2) && !s.ovf;
                n.st = 0; n.len = 0; n.ovf = 0; n.arun = 0;
            end else if (cl == 1) begin
                n.arun = (s.st == 2) ? 1 : ((s.arun < 15) ? s.arun + 1 : 15);
                n.st = 1;
                n = grow(n, k);
            end else if (s.st == 2 || s.arun >= cfg_min[k]) begin
                n.st = 2;
                n = grow(n, k);
                qual = 1'b1;
            end else begin
                n.st = cfg_strict[k] ? 3 : 0;
                n.len = 0; n.ovf = 0; n.arun = 0;
            end
        end else begin
            if (cl == 0) n.st = 0;
        end
        n.out = qual && !n.ovf;
        return n;
    endfunction

    task automatic send(input logic [7:0] c, input bit v);
        sb_t e;
        @(negedge clk);
        ch = c;
        char_valid = v;
        for (int k = 0; k < 4; k++) begin
            mdl[k] = step(mdl[k], k, c, v);
            e.k = k;
            e.v = pack(mdl[k]);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("u%0d ch=%02h v=%0d", e.k, c, v), obs(e.k), e.v);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 4; k++) chk($sformatf("%s u%0d", tag, k), obs(k), 16'h0000);
    endtask

    initial begin
        string alpha;
        alpha = "ab_Z09 .";
        rst_n = 1'b0;
        char_valid = 1'b0;
        ch = 8'h00;
        for (int k = 0; k < 4; k++) mdl[k] = mzero();
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Reset asserted mid-token, between clock edges
        send_str("ab1");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        for (int k = 0; k < 4; k++) mdl[k] = mzero();
        @(negedge clk);
        char_valid = 1'b0;
        rst_n = 1'b1;
        send_str("a");
        send_str("1");
        chk("post_reset out", {15'b0, out_w[0]}, 16'd1);
        send_str(" ");

        send_str("ab12");
        chk("ab12 out", {15'b0, out_w[0]}, 16'd1);
        send_str(" ");
        chk("ab12 tok", {done_w[0], tl0, ok_w[0]}, {9'b0, 1'b1, 5'd4, 1'b1});
        send_str(" ");
        chk("ab12 after", {done_w[0], len0}, 16'd0);

        send_str("a1 ab1 ");
        chk("min2 tok", {done_w[1], tl1, ok_w[1]}, {9'b0, 1'b1, 5'd3, 1'b1});

        send_str("9a1 ");
        chk("strict0 tok", {done_w[0], tl0}, {10'b0, 1'b1, 5'd2});
        chk("strict1 tok", {15'b0, done_w[2]}, 16'd0);

        send_str("abcd1");
        chk("maxlen ovf", {ovf_w[3], len3, out_w[3]}, {11'b0, 1'b1, 3'd4, 1'b0});
        send_str("2 ");
        chk("maxlen tok", {done_w[3], tl3, ok_w[3], ovf_w[3]}, {10'b0, 1'b1, 3'd4, 1'b0, 1'b0});

        send_str("a");
        repeat (3) send(8'h31, 1'b0);
        chk("stall hold", {out_w[0], len0}, {10'b0, 1'b0, 5'd1});
        send_str("1");
        chk("stall out", {15'b0, out_w[0]}, 16'd1);
        send_str(" ");

        send_str("_x9");
`ifdef IDENT_UNDERSCORE_EN
        chk("underscore", {out_w[0], len0}, {10'b0, 1'b1, 5'd3});
`else
        chk("underscore", {out_w[0], len0}, {10'b0, 1'b1, 5'd2});
`endif
        send_str(" ");

        // Long run drives u0 into saturation and the letter-run counter past 15
        repeat (35) send_str("a");
        send_str("1");
        chk("long ovf", {ovf_w[0], len0, out_w[0]}, {9'b0, 1'b1, 5'd31, 1'b0});
        send_str(" ");
        chk("long tok", {done_w[0], tl0, ok_w[0]}, {9'b0, 1'b1, 5'd31, 1'b0});

        for (int i = 0; i < 400; i++)
            send(alpha[$urandom_range(0, 7)], $urandom_range(0, 3) != 0);
        send_str(" ");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
